sram_stream_reader: RTL

Streaming read engine for the SRAM-to-comparison datapath. On a start command it walks a contiguous address range in a fixed-latency SRAM and presents the words on a ready/valid output, normally into the skid buffer in front of the comparison block. Full backpressure is honoured without losing in-flight reads by credit-limiting issue against a small internal FIFO.

---
 rtl/sram_stream_reader.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/sram_stream_reader.sv
// -----------------------------------------------------------------------------
// sram_stream_reader
//
// Streaming read engine: on a start command it reads len consecutive words
// from a fixed-latency SRAM, starting at base_addr (address wraps mod
// 2^ADDR_W), and presents them on a ready/valid stream. Reads are
// credit-limited against an internal FIFO of RD_LAT+2 entries, so reads that
// are still in flight always have a FIFO slot, however long ready_i is held
// low.
//
// Ports
//   clk           in   clock
//   rstn          in   asynchronous active-low reset
//   start_i       in   command pulse, only sampled in IDLE
//   base_addr_i   in   first word address, sampled with start_i
//   len_i         in   number of words to read, sampled with start_i
//   busy_o        out  transfer in progress (RUN or DRAIN)
//   done_o        out  one-cycle completion pulse
//   sram_re_o     out  SRAM read enable
//   sram_addr_o   out  SRAM read address
//   sram_rdata_i  in   SRAM read data, valid RD_LAT cycles after sram_re_o
//   valid_o       out  stream word valid
//   ready_i       in   downstream ready
//   data_o        out  stream word
//   last_o        out  final word of the transfer, qualified by valid_o
// -----------------------------------------------------------------------------
module sram_stream_reader #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 2,
    parameter int LEN_W  = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              sram_re_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    input  logic [DATA_W-1:0] sram_rdata_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic              last_o
);

    localparam int DEPTH = RD_LAT + 2;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state_q,   state_d;
    logic [ADDR_W-1:0]  addr_q,    addr_d;     // address of the next read
    logic [LEN_W-1:0]   remain_q,  remain_d;   // reads still to issue
    logic [CNT_W-1:0]   pending_q, pending_d;  // FIFO occupancy + reads in flight
    logic [RD_LAT-1:0]  vld_sr_q,  vld_sr_d;   // one bit per read in flight
    logic [RD_LAT-1:0]  last_sr_q, last_sr_d;  // last-word flag beside vld_sr_q
    logic [PTR_W-1:0]   wr_ptr_q,  wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q,  rd_ptr_d;
    logic [CNT_W-1:0]   count_q,   count_d;

    // FIFO entry: {last flag, data word}
    logic [DATA_W:0]    fifo_mem_q [DEPTH];
    logic [DATA_W:0]    head;

    logic issue;
    logic wr_en;
    logic pop;

    // Credit check uses the registered pending count only, so an issue and a
    // pop in the same cycle never combine into a combinational path.
    assign issue  = (state_q == S_RUN) && (pending_q < DEPTH_C);
    assign wr_en  = vld_sr_q[RD_LAT-1];
    assign pop    = valid_o && ready_i;
    assign head   = fifo_mem_q[rd_ptr_q];

    assign valid_o     = (count_q != '0);
    // Head entry is masked while empty so the uninitialised storage never
    // reaches the outputs.
    assign data_o      = valid_o ? head[DATA_W-1:0] : '0;
    assign last_o      = valid_o && head[DATA_W];
    assign sram_re_o   = issue;
    assign sram_addr_o = addr_q;
    assign busy_o      = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done_o      = (state_q == S_DONE);

    // NOTE: every signal driven here gets its default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        remain_d  = remain_q;
        pending_d = pending_q;
        vld_sr_d  = vld_sr_q;
        last_sr_d = last_sr_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    addr_d   = base_addr_i;
                    remain_d = len_i;
                    state_d  = (len_i == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (issue && (remain_q == LEN_W'(1))) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pop && last_o) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (issue) begin
            addr_d   = addr_q + ADDR_W'(1);
            remain_d = remain_q - LEN_W'(1);
        end

        // In-flight tracking: bit i set means a read issued i+1 cycles ago.
        vld_sr_d[0]  = issue;
        last_sr_d[0] = issue && (remain_q == LEN_W'(1));
        for (int i = 1; i < RD_LAT; i++) begin
            vld_sr_d[i]  = vld_sr_q[i-1];
            last_sr_d[i] = last_sr_q[i-1];
        end

        unique case ({issue, pop})
            2'b10:   pending_d = pending_q + CNT_W'(1);
            2'b01:   pending_d = pending_q - CNT_W'(1);
            default: pending_d = pending_q;
        endcase

        if (wr_en) begin
            wr_ptr_d = (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        unique case ({wr_en, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the values from before the edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            remain_q  <= '0;
            pending_q <= '0;
            vld_sr_q  <= '0;
            last_sr_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            remain_q  <= remain_d;
            pending_q <= pending_d;
            vld_sr_q  <= vld_sr_d;
            last_sr_q <= last_sr_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    // NOTE: FIFO storage has no reset; emptiness is tracked by count_q, and
    // clearing vld_sr_q on reset drops any SRAM data still returning.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            fifo_mem_q[wr_ptr_q] <= {last_sr_q[RD_LAT-1], sram_rdata_i};
        end
    end

endmodule
